// File: rtl/instruction_record_table.sv
// Four-slot table of in-flight instruction records, indexed by instIndex[1:0].
// Each slot tracks per-element completion in a 128-bit mask; protocol violations latch a sticky error.
module instruction_record_table #(
    parameter int ENTRIES = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enq_valid,
    output logic         enq_ready,
    input  logic         enq_bits_vd_valid,
    input  logic [4:0]   enq_bits_vd_bits,
    input  logic         enq_bits_vs1_valid,
    input  logic [4:0]   enq_bits_vs1_bits,
    input  logic [4:0]   enq_bits_vs2,
    input  logic         enq_bits_gather,
    input  logic         enq_bits_gather16,
    input  logic         enq_bits_onlyRead,
    input  logic [2:0]   enq_bits_instIndex,
    input  logic         progress_valid,
    input  logic [2:0]   progress_instIndex,
    input  logic [127:0] progress_mask,
    input  logic         retire_valid,
    input  logic [2:0]   retire_instIndex,
    output logic         record_0_valid,
    output logic         record_0_bits_vd_valid,
    output logic [4:0]   record_0_bits_vd_bits,
    output logic         record_0_bits_vs1_valid,
    output logic [4:0]   record_0_bits_vs1_bits,
    output logic [4:0]   record_0_bits_vs2,
    output logic         record_0_bits_gather,
    output logic         record_0_bits_gather16,
    output logic         record_0_bits_onlyRead,
    output logic [2:0]   record_0_bits_instIndex,
    output logic [127:0] record_0_bits_elementMask,
    output logic         record_1_valid,
    output logic         record_1_bits_vd_valid,
    output logic [4:0]   record_1_bits_vd_bits,
    output logic         record_1_bits_vs1_valid,
    output logic [4:0]   record_1_bits_vs1_bits,
    output logic [4:0]   record_1_bits_vs2,
    output logic         record_1_bits_gather,
    output logic         record_1_bits_gather16,
    output logic         record_1_bits_onlyRead,
    output logic [2:0]   record_1_bits_instIndex,
    output logic [127:0] record_1_bits_elementMask,
    output logic         record_2_valid,
    output logic         record_2_bits_vd_valid,
    output logic [4:0]   record_2_bits_vd_bits,
    output logic         record_2_bits_vs1_valid,
    output logic [4:0]   record_2_bits_vs1_bits,
    output logic [4:0]   record_2_bits_vs2,
    output logic         record_2_bits_gather,
    output logic         record_2_bits_gather16,
    output logic         record_2_bits_onlyRead,
    output logic [2:0]   record_2_bits_instIndex,
    output logic [127:0] record_2_bits_elementMask,
    output logic         record_3_valid,
    output logic         record_3_bits_vd_valid,
    output logic [4:0]   record_3_bits_vd_bits,
    output logic         record_3_bits_vs1_valid,
    output logic [4:0]   record_3_bits_vs1_bits,
    output logic [4:0]   record_3_bits_vs2,
    output logic         record_3_bits_gather,
    output logic         record_3_bits_gather16,
    output logic         record_3_bits_onlyRead,
    output logic [2:0]   record_3_bits_instIndex,
    output logic [127:0] record_3_bits_elementMask,
    output logic [2:0]   count,
    output logic         empty,
    output logic         error
);

    // Packed record layout: {vd_valid, vd_bits, vs1_valid, vs1_bits, vs2, gather, gather16, onlyRead, instIndex}
    logic [ENTRIES-1:0] r_valid;
    logic [22:0]        r_info [ENTRIES];
    logic [127:0]       r_mask [ENTRIES];
    logic [2:0]         r_count;
    logic               r_error;

    logic [1:0]         w_enq_slot;
    logic               w_enq_fire;
    logic [22:0]        w_enq_info;
    logic [ENTRIES-1:0] w_enq_hit;
    logic [ENTRIES-1:0] w_ret_hit;
    logic [ENTRIES-1:0] w_prog_hit;
    logic               w_ret_any;
    logic               w_prog_any;

    assign w_enq_slot = enq_bits_instIndex[1:0];
    assign enq_ready  = ~r_valid[w_enq_slot];
    assign w_enq_fire = enq_valid & ~r_valid[w_enq_slot];
    assign w_enq_info = {enq_bits_vd_valid, enq_bits_vd_bits, enq_bits_vs1_valid, enq_bits_vs1_bits,
                         enq_bits_vs2, enq_bits_gather, enq_bits_gather16, enq_bits_onlyRead,
                         enq_bits_instIndex};

    // Progress and retire must match the full 3-bit index of a live slot, so stale wrap generations are rejected.
    always_comb begin
        w_enq_hit  = '0;
        w_ret_hit  = '0;
        w_prog_hit = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_enq_hit[i]  = w_enq_fire && (w_enq_slot == 2'(i));
            w_ret_hit[i]  = retire_valid && r_valid[i] && (r_info[i][2:0] == retire_instIndex)
                            && (retire_instIndex[1:0] == 2'(i));
            w_prog_hit[i] = progress_valid && r_valid[i] && (r_info[i][2:0] == progress_instIndex)
                            && (progress_instIndex[1:0] == 2'(i));
        end
    end

    assign w_ret_any  = |w_ret_hit;
    assign w_prog_any = |w_prog_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_info[i] <= '0;
                r_mask[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_ret_hit[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_enq_hit[i]) begin
                    r_valid[i] <= 1'b1;
                end
                // A fresh enq needs an invalid slot and progress a valid one, so the two never collide.
                if (w_enq_hit[i]) begin
                    r_info[i] <= w_enq_info;
                    r_mask[i] <= '0;
                end else if (w_prog_hit[i]) begin
                    r_mask[i] <= r_mask[i] | progress_mask;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_count <= r_count + 3'(w_enq_fire) - 3'(w_ret_any);
            r_error <= r_error | (progress_valid & ~w_prog_any) | (retire_valid & ~w_ret_any);
        end
    end

    assign count = r_count;
    assign empty = (r_count == 3'd0);
    assign error = r_error;

    assign {record_0_valid, record_0_bits_vd_valid, record_0_bits_vd_bits, record_0_bits_vs1_valid,
            record_0_bits_vs1_bits, record_0_bits_vs2, record_0_bits_gather, record_0_bits_gather16,
            record_0_bits_onlyRead, record_0_bits_instIndex, record_0_bits_elementMask}
           = {r_valid[0], r_info[0], r_mask[0]};
    assign {record_1_valid, record_1_bits_vd_valid, record_1_bits_vd_bits, record_1_bits_vs1_valid,
            record_1_bits_vs1_bits, record_1_bits_vs2, record_1_bits_gather, record_1_bits_gather16,
            record_1_bits_onlyRead, record_1_bits_instIndex, record_1_bits_elementMask}
           = {r_valid[1], r_info[1], r_mask[1]};
    assign {record_2_valid, record_2_bits_vd_valid, record_2_bits_vd_bits, record_2_bits_vs1_valid,
            record_2_bits_vs1_bits, record_2_bits_vs2, record_2_bits_gather, record_2_bits_gather16,
            record_2_bits_onlyRead, record_2_bits_instIndex, record_2_bits_elementMask}
           = {r_valid[2], r_info[2], r_mask[2]};
    assign {record_3_valid, record_3_bits_vd_valid, record_3_bits_vd_bits, record_3_bits_vs1_valid,
            record_3_bits_vs1_bits, record_3_bits_vs2, record_3_bits_gather, record_3_bits_gather16,
            record_3_bits_onlyRead, record_3_bits_instIndex, record_3_bits_elementMask}
           = {r_valid[3], r_info[3], r_mask[3]};

endmodule

// File: tb/tb_instruction_record_table.sv
// Bench for instruction_record_table: directed scenarios plus random traffic against a behavioural slot model.
module tb_instruction_record_table;

    logic         clock = 1'b0;
    logic         reset;
    logic         enq_valid, enq_ready;
    logic         enq_bits_vd_valid, enq_bits_vs1_valid, enq_bits_gather, enq_bits_gather16, enq_bits_onlyRead;
    logic [4:0]   enq_bits_vd_bits, enq_bits_vs1_bits, enq_bits_vs2;
    logic [2:0]   enq_bits_instIndex;
    logic         progress_valid;
    logic [2:0]   progress_instIndex;
    logic [127:0] progress_mask;
    logic         retire_valid;
    logic [2:0]   retire_instIndex;
    logic         record_0_valid, record_1_valid, record_2_valid, record_3_valid;
    logic         record_0_bits_vd_valid, record_1_bits_vd_valid, record_2_bits_vd_valid, record_3_bits_vd_valid;
    logic [4:0]   record_0_bits_vd_bits, record_1_bits_vd_bits, record_2_bits_vd_bits, record_3_bits_vd_bits;
    logic         record_0_bits_vs1_valid, record_1_bits_vs1_valid, record_2_bits_vs1_valid, record_3_bits_vs1_valid;
    logic [4:0]   record_0_bits_vs1_bits, record_1_bits_vs1_bits, record_2_bits_vs1_bits, record_3_bits_vs1_bits;
    logic [4:0]   record_0_bits_vs2, record_1_bits_vs2, record_2_bits_vs2, record_3_bits_vs2;
    logic         record_0_bits_gather, record_1_bits_gather, record_2_bits_gather, record_3_bits_gather;
    logic         record_0_bits_gather16, record_1_bits_gather16, record_2_bits_gather16, record_3_bits_gather16;
    logic         record_0_bits_onlyRead, record_1_bits_onlyRead, record_2_bits_onlyRead, record_3_bits_onlyRead;
    logic [2:0]   record_0_bits_instIndex, record_1_bits_instIndex, record_2_bits_instIndex, record_3_bits_instIndex;
    logic [127:0] record_0_bits_elementMask, record_1_bits_elementMask;
    logic [127:0] record_2_bits_elementMask, record_3_bits_elementMask;
    logic [2:0]   count;
    logic         empty, error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [152:0] exp_q[$];

    logic         m_valid [4];
    logic [22:0]  m_f     [4];
    logic [127:0] m_mask  [4];
    logic         m_dc    [4];
    logic [2:0]   m_count;
    logic         m_err;

    always #5 clock = ~clock;

    instruction_record_table #(.ENTRIES(4)) dut (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_bits_vd_valid(enq_bits_vd_valid), .enq_bits_vd_bits(enq_bits_vd_bits),
        .enq_bits_vs1_valid(enq_bits_vs1_valid), .enq_bits_vs1_bits(enq_bits_vs1_bits),
        .enq_bits_vs2(enq_bits_vs2), .enq_bits_gather(enq_bits_gather),
        .enq_bits_gather16(enq_bits_gather16), .enq_bits_onlyRead(enq_bits_onlyRead),
        .enq_bits_instIndex(enq_bits_instIndex),
        .progress_valid(progress_valid), .progress_instIndex(progress_instIndex), .progress_mask(progress_mask),
        .retire_valid(retire_valid), .retire_instIndex(retire_instIndex),
        .record_0_valid(record_0_valid), .record_0_bits_vd_valid(record_0_bits_vd_valid),
        .record_0_bits_vd_bits(record_0_bits_vd_bits), .record_0_bits_vs1_valid(record_0_bits_vs1_valid),
        .record_0_bits_vs1_bits(record_0_bits_vs1_bits), .record_0_bits_vs2(record_0_bits_vs2),
        .record_0_bits_gather(record_0_bits_gather), .record_0_bits_gather16(record_0_bits_gather16),
        .record_0_bits_onlyRead(record_0_bits_onlyRead), .record_0_bits_instIndex(record_0_bits_instIndex),
        .record_0_bits_elementMask(record_0_bits_elementMask),
        .record_1_valid(record_1_valid), .record_1_bits_vd_valid(record_1_bits_vd_valid),
        .record_1_bits_vd_bits(record_1_bits_vd_bits), .record_1_bits_vs1_valid(record_1_bits_vs1_valid),
        .record_1_bits_vs1_bits(record_1_bits_vs1_bits), .record_1_bits_vs2(record_1_bits_vs2),
        .record_1_bits_gather(record_1_bits_gather), .record_1_bits_gather16(record_1_bits_gather16),
        .record_1_bits_onlyRead(record_1_bits_onlyRead), .record_1_bits_instIndex(record_1_bits_instIndex),
        .record_1_bits_elementMask(record_1_bits_elementMask),
        .record_2_valid(record_2_valid), .record_2_bits_vd_valid(record_2_bits_vd_valid),
        .record_2_bits_vd_bits(record_2_bits_vd_bits), .record_2_bits_vs1_valid(record_2_bits_vs1_valid),
        .record_2_bits_vs1_bits(record_2_bits_vs1_bits), .record_2_bits_vs2(record_2_bits_vs2),
        .record_2_bits_gather(record_2_bits_gather), .record_2_bits_gather16(record_2_bits_gather16),
        .record_2_bits_onlyRead(record_2_bits_onlyRead), .record_2_bits_instIndex(record_2_bits_instIndex),
        .record_2_bits_elementMask(record_2_bits_elementMask),
        .record_3_valid(record_3_valid), .record_3_bits_vd_valid(record_3_bits_vd_valid),
        .record_3_bits_vd_bits(record_3_bits_vd_bits), .record_3_bits_vs1_valid(record_3_bits_vs1_valid),
        .record_3_bits_vs1_bits(record_3_bits_vs1_bits), .record_3_bits_vs2(record_3_bits_vs2),
        .record_3_bits_gather(record_3_bits_gather), .record_3_bits_gather16(record_3_bits_gather16),
        .record_3_bits_onlyRead(record_3_bits_onlyRead), .record_3_bits_instIndex(record_3_bits_instIndex),
        .record_3_bits_elementMask(record_3_bits_elementMask),
        .count(count), .empty(empty), .error(error)
    );

    task automatic check_eq(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [151:0] obs_slot(input int i);
        case (i)
            0: return {record_0_valid, record_0_bits_vd_valid, record_0_bits_vd_bits, record_0_bits_vs1_valid,
                       record_0_bits_vs1_bits, record_0_bits_vs2, record_0_bits_gather, record_0_bits_gather16,
                       record_0_bits_onlyRead, record_0_bits_instIndex, record_0_bits_elementMask};
            1: return {record_1_valid, record_1_bits_vd_valid, record_1_bits_vd_bits, record_1_bits_vs1_valid,
                       record_1_bits_vs1_bits, record_1_bits_vs2, record_1_bits_gather, record_1_bits_gather16,
                       record_1_bits_onlyRead, record_1_bits_instIndex, record_1_bits_elementMask};
            2: return {record_2_valid, record_2_bits_vd_valid, record_2_bits_vd_bits, record_2_bits_vs1_valid,
                       record_2_bits_vs1_bits, record_2_bits_vs2, record_2_bits_gather, record_2_bits_gather16,
                       record_2_bits_onlyRead, record_2_bits_instIndex, record_2_bits_elementMask};
            default: return {record_3_valid, record_3_bits_vd_valid, record_3_bits_vd_bits, record_3_bits_vs1_valid,
                       record_3_bits_vs1_bits, record_3_bits_vs2, record_3_bits_gather, record_3_bits_gather16,
                       record_3_bits_onlyRead, record_3_bits_instIndex, record_3_bits_elementMask};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_f[i]     = '0;
            m_mask[i]  = '0;
            m_dc[i]    = 1'b0;
        end
        m_count = '0;
        m_err   = 1'b0;
    endtask

    // Next state from the pre-edge model state and the inputs currently driven.
    task automatic model_step();
        logic [1:0] es, rs, ps;
        logic       fire, rok, pok;
        es   = enq_bits_instIndex[1:0];
        rs   = retire_instIndex[1:0];
        ps   = progress_instIndex[1:0];
        fire = enq_valid && !m_valid[es];
        rok  = retire_valid && m_valid[rs] && (m_f[rs][2:0] == retire_instIndex);
        pok  = progress_valid && m_valid[ps] && (m_f[ps][2:0] == progress_instIndex);
        if ((retire_valid && !rok) || (progress_valid && !pok)) m_err = 1'b1;
        if (pok) begin
            if (rok && rs == ps) m_dc[ps] = 1'b1;
            else m_mask[ps] = m_mask[ps] | progress_mask;
        end
        if (rok) m_valid[rs] = 1'b0;
        if (fire) begin
            m_valid[es] = 1'b1;
            m_f[es]     = {enq_bits_vd_valid, enq_bits_vd_bits, enq_bits_vs1_valid, enq_bits_vs1_bits,
                           enq_bits_vs2, enq_bits_gather, enq_bits_gather16, enq_bits_onlyRead,
                           enq_bits_instIndex};
            m_mask[es]  = '0;
            m_dc[es]    = 1'b0;
        end
        if (fire && !rok) m_count = m_count + 3'd1;
        else if (!fire && rok) m_count = m_count - 3'd1;
    endtask

    task automatic push_expect();
        for (int i = 0; i < 4; i++) exp_q.push_back({m_dc[i], m_valid[i], m_f[i], m_mask[i]});
        exp_q.push_back({1'b0, 147'b0, m_count, (m_count == 3'd0), m_err});
    endtask

    task automatic compare_outputs();
        logic [152:0] e;
        logic [151:0] o;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            o = obs_slot(i);
            if (e[152]) begin
                e[127:0] = '0;
                o[127:0] = '0;
            end
            check_eq($sformatf("slot%0d", i), o, e[151:0]);
        end
        e = exp_q.pop_front();
        check_eq("status", {147'b0, count, empty, error}, e[151:0]);
    endtask

    task automatic idle();
        enq_valid      = 1'b0;
        progress_valid = 1'b0;
        retire_valid   = 1'b0;
    endtask

    task automatic enq(input logic [2:0] idx, input logic [4:0] vd);
        enq_valid          = 1'b1;
        enq_bits_instIndex = idx;
        enq_bits_vd_bits   = vd;
        enq_bits_vd_valid  = 1'($urandom_range(0, 1));
        enq_bits_vs1_valid = 1'($urandom_range(0, 1));
        enq_bits_vs1_bits  = 5'($urandom_range(0, 31));
        enq_bits_vs2       = 5'($urandom_range(0, 31));
        enq_bits_gather    = 1'($urandom_range(0, 1));
        enq_bits_gather16  = 1'($urandom_range(0, 1));
        enq_bits_onlyRead  = 1'($urandom_range(0, 1));
    endtask

    task automatic prog(input logic [2:0] idx, input logic [127:0] m);
        progress_valid     = 1'b1;
        progress_instIndex = idx;
        progress_mask      = m;
    endtask

    task automatic ret(input logic [2:0] idx);
        retire_valid     = 1'b1;
        retire_instIndex = idx;
    endtask

    // Called at a negedge with inputs set; returns at the following negedge with valids dropped.
    task automatic step();
        #1;
        check_eq("enq_ready", 152'(enq_ready), 152'(!m_valid[enq_bits_instIndex[1:0]]));
        model_step();
        push_expect();
        @(posedge clock);
        #1;
        compare_outputs();
        @(negedge clock);
        idle();
    endtask

    initial begin
        logic [1:0]   s;
        logic [2:0]   idx;
        logic [127:0] rm;
        reset = 1'b0;
        idle();
        enq_bits_instIndex = '0;
        enq_bits_vd_valid = 1'b0; enq_bits_vd_bits = '0; enq_bits_vs1_valid = 1'b0; enq_bits_vs1_bits = '0;
        enq_bits_vs2 = '0; enq_bits_gather = 1'b0; enq_bits_gather16 = 1'b0; enq_bits_onlyRead = 1'b0;
        progress_instIndex = '0; progress_mask = '0; retire_instIndex = '0;
        model_reset();
        #3;
        push_expect();
        compare_outputs();
        check_eq("ready_in_reset", 152'(enq_ready), 152'(1));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        enq(3'd5, 5'd8); step();
        check_eq("enq5_vd", 152'(record_1_bits_vd_bits), 152'(8));
        check_eq("enq5_count", 152'(count), 152'(1));
        check_eq("enq5_empty", 152'(empty), 152'(0));

        prog(3'd5, 128'hFF);   step();
        prog(3'd5, 128'hFF00); step();
        check_eq("mask_ffff", 152'(record_1_bits_elementMask), 152'(128'hFFFF));
        prog(3'd1, '1); step();
        check_eq("bad_prog_err", 152'(error), 152'(1));
        check_eq("bad_prog_mask", 152'(record_1_bits_elementMask), 152'(128'hFFFF));

        enq(3'd1, 5'd3); step();
        check_eq("blocked_enq_vd", 152'(record_1_bits_vd_bits), 152'(8));
        ret(3'd5); enq(3'd1, 5'd4); step();
        check_eq("ret_enq_valid", 152'(record_1_valid), 152'(0));
        check_eq("ret_enq_count", 152'(count), 152'(0));
        enq(3'd1, 5'd4); step();
        check_eq("reenq_inst", 152'(record_1_bits_instIndex), 152'(1));

        enq(3'd0, 5'd10); step();
        enq(3'd2, 5'd11); step();
        enq(3'd3, 5'd12); step();
        check_eq("full_count", 152'(count), 152'(4));
        for (int i = 0; i < 4; i++) begin
            enq_bits_instIndex = 3'(i);
            #1;
            check_eq($sformatf("full_ready%0d", i), 152'(enq_ready), 152'(0));
        end
        @(negedge clock);
        ret(3'd2); enq(3'd6, 5'd13); step();
        check_eq("ret2_valid", 152'(record_2_valid), 152'(0));
        check_eq("ret2_count", 152'(count), 152'(3));

        ret(3'd3); prog(3'd3, '1); step();
        check_eq("ret_prog_valid", 152'(record_3_valid), 152'(0));
        enq(3'd6, 5'd9); prog(3'd6, '1); step();
        check_eq("enq_prog_mask", 152'(record_2_bits_elementMask), 152'(0));
        check_eq("enq_prog_valid", 152'(record_2_valid), 152'(1));

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 1) == 1) enq(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 2) != 0) begin
                s   = 2'($urandom_range(0, 3));
                idx = ($urandom_range(0, 3) != 0) ? m_f[s][2:0] : 3'($urandom_range(0, 7));
                rm  = {$urandom, $urandom, $urandom, $urandom};
                prog(idx, rm);
            end
            if ($urandom_range(0, 2) == 0) begin
                s   = 2'($urandom_range(0, 3));
                idx = ($urandom_range(0, 3) != 0) ? m_f[s][2:0] : 3'($urandom_range(0, 7));
                ret(idx);
            end
            step();
        end

        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        enq(3'd0, 5'd1); step();
        enq(3'd5, 5'd2); step();
        enq(3'd2, 5'd3); prog(3'd7, '1); step();
        check_eq("live3_count", 152'(count), 152'(3));
        check_eq("live3_err", 152'(error), 152'(1));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        push_expect();
        compare_outputs();
        check_eq("async_ready", 152'(enq_ready), 152'(1));
        @(negedge clock);
        reset = 1'b1;
        enq(3'd3, 5'd7); step();
        check_eq("post_reset_enq", 152'(record_3_valid), 152'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_record_table.md
INSTRUCTION_RECORD_TABLE -- requirements
Module: instruction_record_table

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 4, meaning the number of in-flight record slots; fixed at 4 because instIndex carries 2 slot bits plus 1 wrap bit.
REQ-002 The block SHALL have the port clock, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, width 1: asynchronous, active-low reset.
REQ-004 The block SHALL have the port enq_valid, input, width 1: an issue request is present.
REQ-005 The block SHALL have the port enq_ready, output, width 1: the target slot is free.
REQ-006 The block SHALL have the ports enq_bits_vd_valid/vs1_valid/gather/gather16/onlyRead, input, width 1 each: record flags.
REQ-007 The block SHALL have the ports enq_bits_vd_bits/vs1_bits/vs2, input, width 5 each: register numbers.
REQ-008 The block SHALL have the port enq_bits_instIndex, input, width 3: instruction index, bit 2 is the wrap bit.
REQ-009 The block SHALL have the ports progress_valid (input, 1), progress_instIndex (input, 3) and progress_mask (input, 128): element-completion report.
REQ-010 The block SHALL have the ports retire_valid (input, 1) and retire_instIndex (input, 3): release of a record.
REQ-011 The block SHALL have the ports record_N_valid and the record_N_bits_* fields for N=0..3, output, same widths as enq_bits plus elementMask of width 128: the stored slot N.
REQ-012 The block SHALL have the port count, output, width 3: number of valid slots, range 0..4.
REQ-013 The block SHALL have the port empty, output, width 1: count==0.
REQ-014 The block SHALL have the port error, output, width 1: sticky protocol violation.

Function
REQ-015 The slot index SHALL be instIndex[1:0]; each slot stores all enq_bits fields plus a 128-bit elementMask, where bit=1 means the element is written or read (no hazard) and bit=0 means the element is pending.
REQ-016 enq_ready SHALL equal ~record_valid[enq_bits_instIndex[1:0]], taken from registered state only, with no same-cycle bypass from retire.
REQ-017 An enq fires on enq_valid & enq_ready; at the next edge the slot becomes valid, its fields load, and its elementMask loads 128'h0.
REQ-018 Progress SHALL apply only when progress_valid is high, the slot is valid before the edge, and the stored 3-bit instIndex equals progress_instIndex in full; the result is elementMask |= progress_mask.
REQ-019 Progress whose slot is invalid or whose instIndex does not match SHALL be dropped and SHALL set error.
REQ-020 Progress SHALL NOT apply to a slot enqueued in the same cycle; that slot's mask SHALL read 0 afterward.
REQ-021 Retire SHALL clear record_valid for the slot when the stored instIndex matches in full; an invalid or mismatched retire SHALL be ignored and SHALL set error.
REQ-022 When retire and progress target the same slot in the same cycle, retire SHALL win; the mask value is then don't-care.
REQ-023 When enq and retire target the same slot in the same cycle, the slot SHALL retire and the enq SHALL NOT fire (enq_ready was 0).
REQ-024 Events on different slots in the same cycle SHALL all take effect independently.
REQ-025 count SHALL be registered and updated by +enq_fire -retire_hit each cycle; simultaneous enq and retire SHALL leave it unchanged; it SHALL never wrap.
REQ-026 All record outputs SHALL be registered: one-cycle latency from an accepted event to the visible change, and no combinational path from inputs to record_*.
REQ-027 Fields of an invalid slot SHALL hold their last values; consumers SHALL qualify them with record_N_valid.

Reset
REQ-028 While reset is low, all record_N_valid, count and error SHALL be 0, empty SHALL be 1, and enq_ready SHALL be 1; the effect is immediate and independent of clock.
REQ-029 Assertion of reset mid-operation SHALL discard all records; the first enq after deassertion SHALL be accepted on the next edge.
REQ-030 The data fields and elementMask SHALL reset to 0.

Verification
REQ-031 Enq instIndex=5, vd=8 -> next cycle record_1_valid=1, vd_bits=8, elementMask=0, count=1, empty=0.
REQ-032 Progress instIndex=5, mask=0xFF, then mask=0xFF00 -> elementMask=0xFFFF; progress instIndex=1 -> dropped, error=1.
REQ-033 Slot 1 valid; enq instIndex=1 -> enq_ready=0, no change; retire 5 and enq 1 in the same cycle -> slot empty, count decremented; enq 1 on the next cycle is accepted.
REQ-034 Fill instIndex 0..3 -> count=4, all enq_ready=0; retire 2 while enq 6 -> slot 2 stays invalid after the edge, count=3.
REQ-035 Retire and progress on the same slot in the same cycle -> valid=0; enq and progress on the same slot -> mask=0.
REQ-036 Reset asserted asynchronously with 3 records live -> outputs clear without a clock edge; error clears.
